// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative RV32M divide / remainder unit (DIV, DIVU, REM, REMU)
//
// Sits in the execute stage. Operands come from the register file read ports.
// The completion pulse, destination and value feed the register file write
// port: done -> write_enable, rd_out -> write_address, result -> write_data.
// While a division is in flight, busy stalls instruction issue.
//
// Algorithm: restoring radix-2 division, one quotient bit per clock, MSB
// first. Signed operations divide magnitudes, then fix the signs afterwards.
// Divide-by-zero and signed overflow skip the iteration and complete after
// one cycle.
//
// Timing (start sampled at edge N):
//   normal  : CALC at edges N+1..N+XLEN, FIX at N+XLEN+1, done high for the
//             one cycle that follows (XLEN+2 cycles after the start cycle)
//   special : done high in the cycle right after edge N
//
// Parameters
//   XLEN      operand/result width; also the number of iterations
//
// Ports
//   clk       in   1     clock, all state changes on posedge
//   rst       in   1     asynchronous active-high reset, aborts any division
//   start     in   1     request, only looked at while idle
//   op        in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data  in   XLEN  dividend
//   rs2_data  in   XLEN  divisor
//   rd_addr   in   5     destination register, captured with start
//   flush     in   1     (DIV_UNIT_FLUSH_EN only) synchronous kill
//   busy      out  1     high in CALC, FIX and DONE
//   done      out  1     one-cycle completion pulse
//   result    out  XLEN  quotient or remainder, held until the next completion
//   rd_out    out  5     destination of the last completed operation
//
// Configuration
//   DIV_UNIT_FLUSH_EN  when defined, adds the flush input. A flush sampled in
//                      CALC or FIX abandons the operation without a done
//                      pulse. A flush sampled in IDLE drops a simultaneous
//                      start. result and rd_out are never touched by a flush.
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
`ifdef DIV_UNIT_FLUSH_EN
  input  logic            flush,
`endif
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Operation context captured at start
  logic [1:0]      op_reg;
  logic [4:0]      rd_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;

  // Datapath: dvd_reg holds the dividend and gradually fills with quotient
  // bits from the bottom as dividend bits are shifted out of the top.
  logic [XLEN-1:0] dvd_reg;
  logic [XLEN-1:0] dvs_reg;
  logic [XLEN-1:0] rem_reg;
  logic [CW-1:0]   count_reg;

  // Registered outputs
  logic [XLEN-1:0] result_reg;
  logic [4:0]      rd_out_reg;

  // ---------------------------------------------------------------------------
  // Flush qualifier: constant low when the feature is not built in
  // ---------------------------------------------------------------------------
  logic flush_active;
`ifdef DIV_UNIT_FLUSH_EN
  assign flush_active = flush;
`else
  assign flush_active = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Operand preparation (used only on the accepting edge)
  // ---------------------------------------------------------------------------
  logic            is_signed;
  logic            is_rem;
  logic            sign1;
  logic            sign2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_by_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_result;
  logic            start_accept;

  assign is_signed = ~op[0];
  assign is_rem    = op[1];
  assign sign1     = is_signed & rs1_data[XLEN-1];
  assign sign2     = is_signed & rs2_data[XLEN-1];
  // abs(most negative) wraps to itself, which is the correct magnitude when
  // read as unsigned.
  assign mag1      = sign1 ? (~rs1_data + 1'b1) : rs1_data;
  assign mag2      = sign2 ? (~rs2_data + 1'b1) : rs2_data;

  assign div_by_zero = (rs2_data == '0);
  assign overflow    = is_signed
                     && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                     && (rs2_data == '1);
  assign special     = div_by_zero | overflow;

  // Divide-by-zero wins over overflow. In the overflow case the quotient is
  // the dividend itself (most negative value) and the remainder is zero.
  always_comb begin
    special_result = '0;
    if (div_by_zero) begin
      special_result = is_rem ? rs1_data : '1;
    end else begin
      special_result = is_rem ? '0 : rs1_data;
    end
  end

  // flush in IDLE takes priority, so the request is simply dropped
  assign start_accept = (state_reg == S_IDLE) && start && !flush_active;

  // ---------------------------------------------------------------------------
  // One restoring step. The shifted partial remainder can reach 2*divisor-1,
  // which needs XLEN+1 bits; the subtraction is done at that width so its top
  // bit is a reliable borrow even for a divisor of all-ones.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] dvd_step;

  assign shifted  = {rem_reg, dvd_reg[XLEN-1]};
  assign diff     = shifted - {1'b0, dvs_reg};
  assign q_bit    = ~diff[XLEN];
  assign rem_step = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign dvd_step = {dvd_reg[XLEN-2:0], q_bit};

  // Sign fix-up applied in FIX
  logic [XLEN-1:0] quot_fixed;
  logic [XLEN-1:0] rem_fixed;

  assign quot_fixed = neg_q_reg ? (~dvd_reg + 1'b1) : dvd_reg;
  assign rem_fixed  = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;

  logic last_iter;
  assign last_iter = (count_reg == CW'(XLEN - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_accept) begin
          state_next = special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush_active) begin
          state_next = S_IDLE;
        end else if (last_iter) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        state_next = flush_active ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg     <= '0;
      rd_reg     <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      rem_reg    <= '0;
      count_reg  <= '0;
      result_reg <= '0;
      rd_out_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_accept) begin
            op_reg    <= op;
            rd_reg    <= rd_addr;
            neg_q_reg <= sign1 ^ sign2;
            neg_r_reg <= sign1;
            dvd_reg   <= mag1;
            dvs_reg   <= mag2;
            rem_reg   <= '0;
            count_reg <= '0;
            // Special cases complete straight away
            if (special) begin
              result_reg <= special_result;
              rd_out_reg <= rd_addr;
            end
          end
        end
        S_CALC: begin
          if (!flush_active) begin
            rem_reg   <= rem_step;
            dvd_reg   <= dvd_step;
            count_reg <= count_reg + 1'b1;
          end
        end
        S_FIX: begin
          // A flush here must leave the visible outputs untouched
          if (!flush_active) begin
            result_reg <= op_reg[1] ? rem_fixed : quot_fixed;
            rd_out_reg <= rd_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = (state_reg != S_IDLE);
  assign done   = (state_reg == S_DONE);
  assign result = result_reg;
  assign rd_out = rd_out_reg;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic [4:0]      rd_addr = '0;
  logic            flush_s = 1'b0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  int compared   = 0;
  int mismatched = 0;

  div_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_addr  (rd_addr),
`ifdef DIV_UNIT_FLUSH_EN
    .flush    (flush_s),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: RISC-V M-extension arithmetic rules
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_result(input logic [1:0] f_op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!f_op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f_op[1] ? r : q;
  endfunction

  function automatic bit ref_special(input logic [1:0] f_op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    return (b == 32'd0) ||
           (!f_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Model state: m_left counts cycles until the done cycle (0 = done now)
  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic [31:0] m_pend = '0;
  logic [4:0]  m_pend_rd = '0;
  logic [31:0] m_result = '0;
  logic [4:0]  m_rd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_left   <= 0;
      m_result <= '0;
      m_rd     <= '0;
    end else if (!m_busy) begin
      if (start && !flush_s) begin
        m_busy    <= 1'b1;
        m_pend    <= ref_result(op, rs1_data, rs2_data);
        m_pend_rd <= rd_addr;
        if (ref_special(op, rs1_data, rs2_data)) begin
          m_left   <= 0;
          m_result <= ref_result(op, rs1_data, rs2_data);
          m_rd     <= rd_addr;
        end else begin
          m_left <= XLEN + 1;
        end
      end
    end else if (flush_s) begin
      m_busy <= 1'b0;
    end else if (m_left == 0) begin
      m_busy <= 1'b0;
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_result <= m_pend;
        m_rd     <= m_pend_rd;
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("done", {31'd0, done}, {31'd0, (m_busy && m_left == 0)});
      check("result", result, m_result);
      check("rd_out", {27'd0, rd_out}, {27'd0, m_rd});
    end
  end

  // ---------------------------------------------------------------------------
  // Directed operation with a hand-computed expectation
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat);
    bit seen = 0;
    @(negedge clk);
    op = o; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1;
        check("lit_latency", i, lat);
        check("lit_result", result, exp);
        check("lit_rd_out", {27'd0, rd_out}, {27'd0, rd});
      end
    end
    check("lit_done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    logic [31:0] saved;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", {27'd0, rd_out}, 32'd0);

    // Basic operations
    run_op(2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 34);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 34);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h10, 5'd6, 32'h0000_000F, 34);
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 34);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, 34);
    run_op(2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 5'd10, 32'd2, 34);
    run_op(2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFFE, 34);
    // Wide-operand boundaries
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd12, 32'hFFFF_FFFF, 34);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'd1, 34);
    run_op(2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFE, 34);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 34);
    run_op(2'b00, 32'h8000_0000, 32'd2, 5'd16, 32'hC000_0000, 34);
    // Special cases
    run_op(2'b00, 32'd42, 32'd0, 5'd7, 32'hFFFF_FFFF, 1);
    run_op(2'b10, 32'd42, 32'd0, 5'd17, 32'd42, 1);
    run_op(2'b01, 32'd42, 32'd0, 5'd18, 32'hFFFF_FFFF, 1);
    run_op(2'b11, 32'hFFFF_FFF0, 32'd0, 5'd19, 32'hFFFF_FFF0, 1);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'd0, 1);
    run_op(2'b00, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1);
    run_op(2'b01, 32'd77, 32'd7, 5'd0, 32'd11, 34);

    // Start while busy is ignored
    @(negedge clk);
    op = 2'b01; rs1_data = 32'd9; rs2_data = 32'd3; rd_addr = 5'd22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 2'b01; rs1_data = 32'd8; rs2_data = 32'd2; rd_addr = 5'd23; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_dones(45, ndone);
    check("busy_start_ndone", ndone, 32'd1);
    check("busy_start_result", result, 32'd3);
    check("busy_start_rd", {27'd0, rd_out}, 32'd22);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd24; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_result", result, 32'd0);
    check("async_rst_rd", {27'd0, rd_out}, 32'd0);
    #1 rst = 1'b0;
    count_dones(40, ndone);
    check("after_rst_ndone", ndone, 32'd0);
    run_op(2'b01, 32'd1000, 32'd3, 5'd24, 32'd333, 34);

`ifdef DIV_UNIT_FLUSH_EN
    // Flush in CALC
    saved = result;
    @(negedge clk);
    op = 2'b01; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr = 5'd25; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    flush_s = 1'b1;
    @(negedge clk);
    flush_s = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    count_dones(40, ndone);
    check("flush_ndone", ndone, 32'd0);
    check("flush_result_kept", result, saved);
    // Flush with start in IDLE
    @(negedge clk);
    op = 2'b01; rs1_data = 32'd50; rs2_data = 32'd5; rd_addr = 5'd26; start = 1'b1; flush_s = 1'b1;
    @(negedge clk);
    start = 1'b0; flush_s = 1'b0;
    check("flush_idle_busy", {31'd0, busy}, 32'd0);
    count_dones(40, ndone);
    check("flush_idle_ndone", ndone, 32'd0);
    run_op(2'b01, 32'd50, 32'd5, 5'd26, 32'd10, 34);
`else
    saved = result;
    check("final_result", saved, 32'd333);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
